ddr_cmd_arb: RTL and testbench

DDR_CMD_ARB -- requirements
Module: ddr_cmd_arb

---
 rtl/ddr_cmd_arb_if.sv | 35 +++
 rtl/ddr_cmd_arb.sv | 120 ++++++++++++
 tb/tb_ddr_cmd_arb.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_cmd_arb_if.sv
// Requester and DDR-controller signal bundle for the two-requester command arbiter.
// slave is the arbiter's view; master is the view of the requesters and controller.
interface ddr_cmd_arb_if;
  localparam int unsigned INST_W = 12;
  localparam int unsigned PAGE_W = 32;

  logic [INST_W-1:0] r0_inst;
  logic [INST_W-1:0] r1_inst;
  logic              r0_valid;
  logic              r1_valid;
  logic              r0_ack;
  logic              r1_ack;
  logic              r0_done;
  logic              r1_done;
  logic [PAGE_W-1:0] r0_page;
  logic [PAGE_W-1:0] r1_page;
  logic [INST_W-1:0] ctl_inst;
  logic              ctl_inst_en;
  logic              ctl_ready;
  logic [PAGE_W-1:0] ctl_page;
  logic              busy;
  logic              owner;

  modport slave (
    input  r0_inst, r1_inst, r0_valid, r1_valid, ctl_ready, ctl_page,
    output r0_ack, r1_ack, r0_done, r1_done, r0_page, r1_page,
           ctl_inst, ctl_inst_en, busy, owner
  );

  modport master (
    output r0_inst, r1_inst, r0_valid, r1_valid, ctl_ready, ctl_page,
    input  r0_ack, r1_ack, r0_done, r1_done, r0_page, r1_page,
           ctl_inst, ctl_inst_en, busy, owner
  );
endinterface

// File: rtl/ddr_cmd_arb.sv
// Round-robin arbiter that feeds one of two requesters' instructions into a DDR controller
// and returns the controller page to the owner when the command completes.
module ddr_cmd_arb #(
  parameter int unsigned BUSY_WAIT = 4
) (
  input logic           clock,
  input logic           reset,
  ddr_cmd_arb_if.slave  bus
);
  localparam int unsigned INST_W = 12;
  localparam int unsigned PAGE_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [INST_W-1:0] inst, inst_nxt;
  logic              inst_en, inst_en_nxt;
  logic [1:0]        ack, ack_nxt;
  logic [1:0]        done, done_nxt;
  logic [PAGE_W-1:0] page0, page0_nxt;
  logic [PAGE_W-1:0] page1, page1_nxt;
  logic              own, own_nxt;
  logic              last, last_nxt;
  logic              busy, busy_nxt;
  logic              win;

  // Requester 1 wins alone, or on a tie when requester 0 was served last.
  always_comb win = (bus.r0_valid && bus.r1_valid) ? ~last : bus.r1_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      inst    <= '0;
      inst_en <= 1'b0;
      ack     <= '0;
      done    <= '0;
      page0   <= '0;
      page1   <= '0;
      own     <= 1'b0;
      last    <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      inst    <= inst_nxt;
      inst_en <= inst_en_nxt;
      ack     <= ack_nxt;
      done    <= done_nxt;
      page0   <= page0_nxt;
      page1   <= page1_nxt;
      own     <= own_nxt;
      last    <= last_nxt;
      busy    <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    inst_nxt    = inst;
    inst_en_nxt = 1'b0;
    ack_nxt     = '0;
    done_nxt    = '0;
    page0_nxt   = page0;
    page1_nxt   = page1;
    own_nxt     = own;
    last_nxt    = last;
    case (state)
      IDLE: begin
        if (bus.ctl_ready && (bus.r0_valid || bus.r1_valid)) begin
          ack_nxt   = win ? 2'b10 : 2'b01;
          inst_nxt  = win ? bus.r1_inst : bus.r0_inst;
          own_nxt   = win;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        inst_en_nxt = 1'b1;
        cnt_nxt     = '0;
        state_nxt   = WAIT_BUSY;
      end
      // A controller that never drops ready within the window finished with zero latency.
      WAIT_BUSY: begin
        if (!bus.ctl_ready) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == CNT_W'(BUSY_WAIT - 1)) begin
          state_nxt = RESPOND;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (bus.ctl_ready) state_nxt = RESPOND;
      end
      RESPOND: begin
        done_nxt = own ? 2'b10 : 2'b01;
        if (own) page1_nxt = bus.ctl_page;
        else     page0_nxt = bus.ctl_page;
        last_nxt  = own;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  assign bus.r0_ack      = ack[0];
  assign bus.r1_ack      = ack[1];
  assign bus.r0_done     = done[0];
  assign bus.r1_done     = done[1];
  assign bus.r0_page     = page0;
  assign bus.r1_page     = page1;
  assign bus.ctl_inst    = inst;
  assign bus.ctl_inst_en = inst_en;
  assign bus.busy        = busy;
  assign bus.owner       = own;
endmodule

// File: tb/tb_ddr_cmd_arb.sv
// Bench for ddr_cmd_arb: random requesters and controller, a command-age reference model
// checked every cycle, plus directed scenarios with hand-computed timings.
module tb_ddr_cmd_arb;
  localparam int unsigned BW = 4;

  logic clock = 1'b0;
  logic reset;
  ddr_cmd_arb_if bus();

  ddr_cmd_arb #(.BUSY_WAIT(BW)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus configuration, written only by the main sequence.
  int          rem0 = 0, rem1 = 0;
  int          inst_fixed0 = -1, inst_fixed1 = -1;
  bit          gap_en = 0, drop_en = 0, glitch_en = 0, hold = 0;
  int          lat_fixed = -1;
  bit          page_fixed_en = 0;
  logic [31:0] page_fixed = '0;

  // Monitor log, written only by the negedge process.
  int   cyc = 0;
  int   ack_cyc = 0, en_cyc = 0, done_cyc = 0;
  int   ack_who = 0, done_who = 0;
  int   ack_tot = 0, en_cnt = 0;
  int   done_cnt[2] = '{0, 0};
  logic [11:0] en_inst = '0;
  int   grants[$];
  bit   prev_en = 0, prev_busy = 0;
  logic [11:0] prev_inst = '0;

  // Reference model: tracks the in-flight command by its age in cycles since ack.
  bit          m_inflight = 0, m_low = 0, m_last = 1;
  int          m_age = 0, m_resp = -1;
  logic        e_ack0 = 0, e_ack1 = 0, e_en = 0, e_done0 = 0, e_done1 = 0;
  logic        e_owner = 0, e_busy = 0;
  logic [31:0] e_page0 = '0, e_page1 = '0;
  logic [11:0] e_inst = '0;

  always @(negedge clock) begin
    logic w;
    logic n_ack0, n_ack1, n_en, n_done0, n_done1;
    cyc++;
    if (reset) begin
      m_inflight = 0; m_low = 0; m_last = 1; m_age = 0; m_resp = -1;
      e_ack0 = 0; e_ack1 = 0; e_en = 0; e_done0 = 0; e_done1 = 0;
      e_owner = 0; e_busy = 0; e_page0 = '0; e_page1 = '0; e_inst = '0;
    end
    chk("r0_ack",   32'(bus.r0_ack),      32'(e_ack0));
    chk("r1_ack",   32'(bus.r1_ack),      32'(e_ack1));
    chk("inst_en",  32'(bus.ctl_inst_en), 32'(e_en));
    chk("r0_done",  32'(bus.r0_done),     32'(e_done0));
    chk("r1_done",  32'(bus.r1_done),     32'(e_done1));
    chk("r0_page",  bus.r0_page,          e_page0);
    chk("r1_page",  bus.r1_page,          e_page1);
    chk("owner",    32'(bus.owner),       32'(e_owner));
    chk("busy",     32'(bus.busy),        32'(e_busy));
    chk("ctl_inst", 32'(bus.ctl_inst),    32'(e_inst));
    chk("ack_onehot",  32'(bus.r0_ack & bus.r1_ack),   32'(0));
    chk("done_onehot", 32'(bus.r0_done & bus.r1_done), 32'(0));
    chk("en_width",    32'(prev_en & bus.ctl_inst_en), 32'(0));
    if (prev_busy && bus.busy) chk("inst_stable", 32'(bus.ctl_inst), 32'(prev_inst));

    if (bus.r0_ack || bus.r1_ack) begin
      ack_cyc = cyc; ack_who = int'(bus.r1_ack); ack_tot++; grants.push_back(int'(bus.r1_ack));
    end
    if (bus.ctl_inst_en) begin en_cyc = cyc; en_cnt++; en_inst = bus.ctl_inst; end
    if (bus.r0_done || bus.r1_done) begin
      done_cyc = cyc; done_who = int'(bus.r1_done); done_cnt[int'(bus.r1_done)]++;
    end

    if (!reset) begin
      n_ack0 = 0; n_ack1 = 0; n_en = 0; n_done0 = 0; n_done1 = 0;
      if (!m_inflight) begin
        if (bus.ctl_ready && (bus.r0_valid || bus.r1_valid)) begin
          w = (bus.r0_valid && bus.r1_valid) ? !m_last : bus.r1_valid;
          if (w) begin n_ack1 = 1; e_inst = bus.r1_inst; end
          else   begin n_ack0 = 1; e_inst = bus.r0_inst; end
          e_owner = w; m_inflight = 1; m_age = 0; m_low = 0; m_resp = -1;
        end
      end else if (m_age == m_resp) begin
        if (e_owner) begin n_done1 = 1; e_page1 = bus.ctl_page; end
        else         begin n_done0 = 1; e_page0 = bus.ctl_page; end
        m_last = e_owner; m_inflight = 0;
      end else begin
        if (m_age == 0) n_en = 1;
        else if (!m_low && !bus.ctl_ready) m_low = 1;
        else if ((m_low && bus.ctl_ready) || (!m_low && m_age == int'(BW))) m_resp = m_age + 1;
        m_age++;
      end
      e_ack0 = n_ack0; e_ack1 = n_ack1; e_en = n_en; e_done0 = n_done0; e_done1 = n_done1;
      e_busy = m_inflight;
    end
    prev_en = bus.ctl_inst_en; prev_busy = bus.busy; prev_inst = bus.ctl_inst;
  end

  // Requesters: hold valid until acked, optionally with gaps and early withdrawals.
  always @(posedge clock) begin
    #2;
    if (reset) begin
      bus.r0_valid = 0; bus.r1_valid = 0;
    end else begin
      if (bus.r0_ack) begin bus.r0_valid = 0; rem0--; end
      else if (bus.r0_valid && drop_en && $urandom_range(0, 15) == 0) bus.r0_valid = 0;
      else if (!bus.r0_valid && rem0 > 0 && (!gap_en || $urandom_range(0, 3) == 0)) begin
        bus.r0_valid = 1;
        bus.r0_inst  = (inst_fixed0 >= 0) ? 12'(inst_fixed0) : 12'($urandom);
      end
      if (bus.r1_ack) begin bus.r1_valid = 0; rem1--; end
      else if (bus.r1_valid && drop_en && $urandom_range(0, 15) == 0) bus.r1_valid = 0;
      else if (!bus.r1_valid && rem1 > 0 && (!gap_en || $urandom_range(0, 3) == 0)) begin
        bus.r1_valid = 1;
        bus.r1_inst  = (inst_fixed1 >= 0) ? 12'(inst_fixed1) : 12'($urandom);
      end
    end
  end

  // Controller: ready drops the cycle after an instruction strobe for a chosen number of cycles.
  int low_left = 0;
  always @(posedge clock) begin
    #2;
    if (reset) begin
      low_left = 0;
      bus.ctl_ready = !hold;
    end else begin
      if (prev_en) low_left = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 6));
      if (hold) bus.ctl_ready = 0;
      else if (low_left > 0) begin bus.ctl_ready = 0; low_left--; end
      else bus.ctl_ready = !(glitch_en && !bus.busy && $urandom_range(0, 7) == 0);
    end
    bus.ctl_page = page_fixed_en ? page_fixed : $urandom;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((rem0 != 0 || rem1 != 0 || bus.r0_valid || bus.r1_valid || bus.busy) && n < budget) begin
      step(1); n++;
    end
    step(2);
    chk({name, "_timeout"}, 32'(n < budget), 32'(1));
  endtask

  initial begin
    int start, d0, d1, tot, rise;
    reset = 1;
    bus.r0_valid = 0; bus.r1_valid = 0; bus.r0_inst = '0; bus.r1_inst = '0;
    bus.ctl_ready = 1; bus.ctl_page = '0;
    step(3);
    chk("rst_busy",  32'(bus.busy), 32'(0));
    chk("rst_owner", 32'(bus.owner), 32'(0));
    chk("rst_inst",  32'(bus.ctl_inst), 32'(0));
    chk("rst_page0", bus.r0_page, 32'(0));
    chk("rst_page1", bus.r1_page, 32'(0));
    reset = 0;
    step(2);

    // Single command with a 5-cycle controller busy period.
    lat_fixed = 5; page_fixed_en = 1; page_fixed = 32'hDEADBEEF; inst_fixed0 = 12'h3A5;
    rem0 = 1;
    wait_idle(100, "single");
    chk("single_who",     32'(ack_who), 32'(0));
    chk("single_en_lat",  32'(en_cyc - ack_cyc), 32'(1));
    chk("single_en_inst", 32'(en_inst), 32'h3A5);
    chk("single_done_lat", 32'(done_cyc - ack_cyc), 32'(9));
    chk("single_done_cnt", 32'(done_cnt[0]), 32'(1));
    chk("single_page0", bus.r0_page, 32'hDEADBEEF);
    chk("single_page1", bus.r1_page, 32'h0);
    page_fixed_en = 0; inst_fixed0 = -1;

    // Zero-latency command on requester 1.
    lat_fixed = 0;
    rem1 = 1;
    wait_idle(100, "zero");
    chk("zero_who",      32'(done_who), 32'(1));
    chk("zero_done_lat", 32'(done_cyc - ack_cyc), 32'(6));

    // Controller not ready for 10 cycles.
    hold = 1; start = ack_tot;
    rem0 = 1;
    step(10);
    chk("nrdy_no_ack", 32'(ack_tot - start), 32'(0));
    chk("nrdy_busy",   32'(bus.busy), 32'(0));
    hold = 0; rise = cyc + 1;
    wait_idle(100, "nrdy");
    chk("nrdy_ack_cyc", 32'(ack_cyc - rise), 32'(1));

    // Reset while the controller holds the command in its busy phase.
    lat_fixed = 8; start = en_cnt;
    rem0 = 1;
    for (int i = 0; i < 50 && en_cnt == start; i++) step(1);
    chk("rst_mid_en_seen", 32'(en_cnt - start), 32'(1));
    step(2);
    tot = done_cnt[0] + done_cnt[1];
    reset = 1; rem0 = 0;
    step(2);
    chk("rst_mid_busy",  32'(bus.busy), 32'(0));
    chk("rst_mid_page0", bus.r0_page, 32'(0));
    reset = 0;
    step(12);
    chk("rst_mid_no_done", 32'(done_cnt[0] + done_cnt[1] - tot), 32'(0));
    lat_fixed = -1; start = grants.size();
    rem0 = 1; rem1 = 1;
    wait_idle(200, "rst_mid");
    chk("rst_mid_first_r0", 32'(grants[start]), 32'(0));

    // Contention: both requesters keep a command pending for four commands each.
    start = grants.size(); d0 = done_cnt[0]; d1 = done_cnt[1];
    rem0 = 4; rem1 = 4;
    wait_idle(400, "cont");
    chk("cont_grants", 32'(grants.size() - start), 32'(8));
    for (int i = start + 1; i < grants.size(); i++) chk("cont_alternate", 32'(grants[i] != grants[i-1]), 32'(1));
    chk("cont_done0", 32'(done_cnt[0] - d0), 32'(4));
    chk("cont_done1", 32'(done_cnt[1] - d1), 32'(4));

    // Random traffic with gaps, withdrawals, idle ready glitches and random latencies.
    gap_en = 1; drop_en = 1; glitch_en = 1;
    rem0 = 30; rem1 = 30;
    wait_idle(6000, "random");
    gap_en = 0; drop_en = 0; glitch_en = 0;
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
